mem_rsp_demux: RTL and testbench
================================

# mem_rsp_demux

Response-side demultiplexer for the shared memory port. The request-side 2:1 mux steers fetch (`s=0`) or LSU (`s=1`) requests onto one bus. This block records the select bit of every accepted request in an in-order tracking FIFO and routes each returning response to the requester that issued it. It sits between the memory/bus response channel and the fetch and LSU response inputs, and enforces the outstanding-request limit via `req_ready`.

## Interface
- `width`, 32, response data width in bits
- `depth`, 4, maximum outstanding requests; power of 2, ≥2
- `clk`  input  1  core clock, rising edge
- `rst_n`  input  1  synchronous active-low reset
- `req_fire`  input  1  request accepted by memory this cycle
- `req_sel`  input  1  source of that request: 0 = port a (fetch), 1 = port b (LSU)
- `req_ready`  output  1  tracking FIFO can accept a request; arbiter must not fire when low
- `rsp_valid`  input  1  memory response valid
- `rsp_data`  input  `width`  memory response data
- `rsp_ready`  output  1  response consumed this cycle
- `a_valid`  output  1  response valid toward port a
- `a_data`  output  `width`  response data toward port a
- `a_ready`  input  1  port a accepts
- `b_valid`  output  1  response valid toward port b
- `b_data`  output  `width`  response data toward port b
- `b_ready`  input  1  port b accepts
- `outstanding`  output  $clog2(depth)+1  number of entries in the tracking FIFO
- `err_overflow`  output  1  sticky: `req_fire` seen while `req_ready`=0
- `err_orphan`  output  1  sticky: `rsp_valid` seen while FIFO empty

## Operation
- Tracking FIFO is `depth` x 1 bit, with a write pointer, a read pointer and a count. `head` is the select bit at the read pointer.
- Push: `req_fire && req_ready` writes `req_sel` and increments the write pointer and the count.
- `req_fire && !req_ready` is dropped (no write) and sets `err_overflow`.
- `req_ready = (count != depth)`. There is no pop-bypass: when full, `req_ready` stays 0 even in a cycle that pops.
- Routing (combinational from head), with `empty = (count == 0)`:
  - `a_valid = rsp_valid && !empty && head==0`
  - `b_valid = rsp_valid && !empty && head==1`
  - `a_data = b_data = rsp_data` unconditionally
- Normal response path: `rsp_ready = !empty && (head ? b_ready : a_ready)`. A handshake pops the FIFO: read pointer +1, count −1.
- Orphan response: `rsp_valid && empty` drives `rsp_ready`=1, so the response is discarded. Neither port is valid and `err_orphan` is set.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push into an empty FIFO has no bypass. A response in the same cycle is treated as an orphan.
- Pointers are modulo `depth` and wrap naturally.
- `outstanding` = count, 0..`depth`.
- Error flags are sticky until reset.

## Timing
- Reset (`rst_n`=0 at a rising edge): pointers, count and both error flags cleared.
- Post-reset output values: `req_ready`=1, `outstanding`=0, `a_valid`=`b_valid`=0, `rsp_ready`=`rsp_valid`.
- Reset mid-operation discards all outstanding entries. A response arriving after reset is an orphan.
- A pushed entry becomes the head one cycle after `req_fire`. The earliest routable response is the cycle after its request fire.
- Response path latency is zero cycles, purely combinational: `rsp_*` to `a_*`/`b_*` and `a_ready`/`b_ready` to `rsp_ready`.
- Stall: while the selected port's ready is low, the response is held by the memory side and the head is unchanged.
- `req_ready` and `outstanding` are register-derived: no combinational path from any input.

## Test plan
- Reset, then push sel=0, 1, 1, 0 on consecutive cycles. Return responses 0x11, 0x22, 0x33, 0x44 with both readies high. Required: 0x11 and 0x44 appear on port a, 0x22 and 0x33 on port b, in order; `outstanding` goes 1, 2, 3, 4, then back to 0.
- Fill to `depth`=4. Required: `req_ready`=0. Fire once more: `err_overflow`=1 and `outstanding` stays 4. Pop one: `req_ready`=1 the next cycle.
- Head sel=1 with `b_ready`=0 for 3 cycles, `rsp_data`=0xDEAD. Required: `b_valid`=1, `rsp_ready`=0, `a_valid`=0 throughout. Raise `b_ready`: a single pop occurs.
- `rsp_valid`=1 with the FIFO empty. Required: `rsp_ready`=1, `a_valid`=`b_valid`=0, and `err_orphan` reads 1 from the next cycle.
- Steady state with count=2, simultaneous push and pop for 10 cycles with alternating sel. Required: count stays 2, pointer wrap-around is correct, routing matches push order.
- 3 requests outstanding, then assert `rst_n`=0 for one cycle. Required: `outstanding`=0, error flags 0, `req_ready`=1. A subsequent response is an orphan.

Source files
------------

// File: rtl/mem_rsp_demux.sv
// Purpose: routes memory responses to fetch (a) or LSU (b) using an in-order record of request sources.
// Latency: response path is combinational (0 cycles); a tracked request becomes routable the cycle after it fires.
// Backpressure: rsp_ready follows the selected port's ready; req_ready drops while depth requests are outstanding.
module mem_rsp_demux #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_fire,
    input  logic                       req_sel,
    output logic                       req_ready,
    input  logic                       rsp_valid,
    input  logic [width-1:0]           rsp_data,
    output logic                       rsp_ready,
    output logic                       a_valid,
    output logic [width-1:0]           a_data,
    input  logic                       a_ready,
    output logic                       b_valid,
    output logic [width-1:0]           b_data,
    input  logic                       b_ready,
    output logic [$clog2(depth):0]     outstanding,
    output logic                       err_overflow,
    output logic                       err_orphan
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [depth-1:0] sel_mem;
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [cw-1:0]    count;
    logic             empty;
    logic             head;
    logic             push;
    logic             pop;

    assign empty       = (count == '0);
    assign head        = sel_mem[rd_ptr];
    assign req_ready   = (count != cw'(depth));
    assign outstanding = count;

    // Route the response toward the port recorded at the head; orphans are swallowed.
    always_comb begin
        a_valid   = rsp_valid && !empty && !head;
        b_valid   = rsp_valid && !empty && head;
        a_data    = rsp_data;
        b_data    = rsp_data;
        rsp_ready = empty ? rsp_valid : (head ? b_ready : a_ready);
    end

    assign push = req_fire && req_ready;
    assign pop  = rsp_valid && !empty && rsp_ready;

    // Source-bit storage; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wr_ptr] <= req_sel;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
            if (req_fire && !req_ready) begin
                err_overflow <= 1'b1;
            end
            if (rsp_valid && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_rsp_demux.sv
// Purpose: checks mem_rsp_demux against a queue-based model plus directed literal expectations.
// Latency: inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Backpressure: random readies, overflow attempts, orphans and mid-run resets are exercised.
module tb_mem_rsp_demux;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_fire;
    logic             req_sel;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic [2:0]       outstanding;
    logic             err_overflow;
    logic             err_orphan;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    // Behavioural model: a queue of requester ids in issue order, plus sticky flags.
    bit q[$];
    bit m_ovf = 0;
    bit m_orph = 0;

    mem_rsp_demux #(.width(WIDTH), .depth(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_fire(req_fire), .req_sel(req_sel), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .outstanding(outstanding), .err_overflow(err_overflow), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Compare DUT against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit emp;
            bit hd;
            bit take;
            emp = (q.size() == 0);
            hd  = emp ? 1'b0 : q[0];
            chk("m_req_ready",   req_ready,   q.size() < DEPTH);
            chk("m_outstanding", outstanding, q.size());
            chk("m_a_valid",     a_valid,     rsp_valid && !emp && hd == 1'b0);
            chk("m_b_valid",     b_valid,     rsp_valid && !emp && hd == 1'b1);
            chk("m_rsp_ready",   rsp_ready,   emp ? rsp_valid : (hd ? b_ready : a_ready));
            chk("m_a_data",      a_data,      rsp_data);
            chk("m_b_data",      b_data,      rsp_data);
            chk("m_err_ovf",     err_overflow, m_ovf);
            chk("m_err_orphan",  err_orphan,  m_orph);
            if (!rst_n) begin
                q.delete();
                m_ovf  = 0;
                m_orph = 0;
            end else begin
                take = rsp_valid && !emp && (hd ? b_ready : a_ready);
                if (rsp_valid && emp) m_orph = 1;
                if (req_fire && q.size() == DEPTH) m_ovf = 1;
                // Fullness is judged before this cycle's pop: no bypass.
                if (req_fire && q.size() < DEPTH) begin
                    if (take) void'(q.pop_front());
                    q.push_back(req_sel);
                end else if (take) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input bit s);
        req_fire = 1; req_sel = s;
        cyc();
        req_fire = 0;
    endtask

    task automatic idle_inputs();
        req_fire = 0; req_sel = 0; rsp_valid = 0; rsp_data = '0; a_ready = 0; b_ready = 0;
    endtask

    initial begin
        bit sels[4];
        idle_inputs();
        rst_n = 0;
        cyc();
        chk_en = 1;
        cyc();
        // Post-reset values
        chk("rst_req_ready", req_ready, 1);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rsp_ready_idle", rsp_ready, 0);
        rst_n = 1;
        cyc();

        // In-order routing of four responses
        sels = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            push1(sels[i]);
            chk("t1_outstanding_up", outstanding, i + 1);
        end
        a_ready = 1; b_ready = 1; rsp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rsp_data = 32'h11 * (i + 1);
            #1;
            chk("t1_a_valid", a_valid, sels[i] == 0);
            chk("t1_b_valid", b_valid, sels[i] == 1);
            chk("t1_data", sels[i] ? b_data : a_data, 32'h11 * (i + 1));
            cyc();
        end
        rsp_valid = 0;
        chk("t1_outstanding_drained", outstanding, 0);

        // Full FIFO, overflow attempt, then one pop frees a slot
        for (int i = 0; i < 4; i++) push1(i[0]);
        chk("t2_full_req_ready", req_ready, 0);
        chk("t2_full_outstanding", outstanding, 4);
        push1(1);
        chk("t2_err_overflow", err_overflow, 1);
        chk("t2_outstanding_held", outstanding, 4);
        rsp_valid = 1;
        cyc();
        rsp_valid = 0;
        chk("t2_req_ready_after_pop", req_ready, 1);
        chk("t2_outstanding_3", outstanding, 3);
        rsp_valid = 1;
        repeat (3) cyc();
        rsp_valid = 0;
        chk("t2_drained", outstanding, 0);

        // Stall on port b
        push1(1);
        rsp_valid = 1; rsp_data = 32'hDEAD; b_ready = 0; a_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_b_valid", b_valid, 1);
            chk("t3_rsp_ready", rsp_ready, 0);
            chk("t3_a_valid", a_valid, 0);
            cyc();
        end
        chk("t3_head_kept", outstanding, 1);
        b_ready = 1;
        #1;
        chk("t3_rsp_ready_go", rsp_ready, 1);
        cyc();
        rsp_valid = 0;
        chk("t3_single_pop", outstanding, 0);

        // Orphan response
        rsp_valid = 1; rsp_data = 32'hBAD;
        #1;
        chk("t4_rsp_ready", rsp_ready, 1);
        chk("t4_a_valid", a_valid, 0);
        chk("t4_b_valid", b_valid, 0);
        cyc();
        rsp_valid = 0;
        chk("t4_err_orphan", err_orphan, 1);

        // Steady push+pop at count 2 across pointer wrap
        push1(0);
        push1(1);
        a_ready = 1; b_ready = 1;
        for (int i = 0; i < 10; i++) begin
            req_fire = 1; req_sel = i[0]; rsp_valid = 1; rsp_data = i;
            #1;
            chk("t5_a_valid", a_valid, i[0] == 1'b0);
            chk("t5_b_valid", b_valid, i[0] == 1'b1);
            cyc();
            chk("t5_count", outstanding, 2);
        end
        req_fire = 0;
        repeat (2) cyc();
        rsp_valid = 0;
        chk("t5_drained", outstanding, 0);

        // Reset with entries outstanding
        for (int i = 0; i < 3; i++) push1(1);
        chk("t6_pre_outstanding", outstanding, 3);
        rst_n = 0;
        cyc();
        rst_n = 1;
        chk("t6_outstanding", outstanding, 0);
        chk("t6_err_overflow", err_overflow, 0);
        chk("t6_err_orphan", err_orphan, 0);
        chk("t6_req_ready", req_ready, 1);
        rsp_valid = 1;
        #1;
        chk("t6_orphan_rsp_ready", rsp_ready, 1);
        chk("t6_orphan_b_valid", b_valid, 0);
        cyc();
        rsp_valid = 0;
        chk("t6_err_orphan_set", err_orphan, 1);

        // Random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            req_fire  = ($urandom_range(0, 99) < 55);
            req_sel   = $urandom_range(0, 1);
            rsp_valid = ($urandom_range(0, 99) < 50);
            rsp_data  = $urandom;
            a_ready   = ($urandom_range(0, 99) < 70);
            b_ready   = ($urandom_range(0, 99) < 70);
            cyc();
        end
        idle_inputs();
        rst_n = 1;
        cyc();
        chk_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
